vending_machine_ctrl: RTL and testbench

Parametrised successor to the single-price Rs5/Rs10 vending FSM. Accumulates credit in Rs5 units against a configurable price and vends one item per purchase. Returns change or a cancel refund as a stream of Rs10/Rs5 coins over a ready/valid handshake, and tracks stock with sold-out coin rejection. Sits between the coin acceptor front-end and the dispenser/change-hopper drivers.

---
 rtl/vending_machine_ctrl_if.sv | 24 ++
 rtl/vending_machine_ctrl.sv | 107 ++++++++++
 tb/tb_vending_machine_ctrl.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/vending_machine_ctrl_if.sv
// vending_machine_ctrl_if: coin, cancel, restock and change-hopper signals of the vending controller
interface vending_machine_ctrl_if #(parameter int CW = 3, parameter int STOCK_W = 4);
  logic               i_coin_valid;
  logic [1:0]         i_coin;
  logic               i_cancel;
  logic               i_restock;
  logic               i_change_ready;
  logic               o_vend;
  logic               o_reject;
  logic               o_change_valid;
  logic [1:0]         o_change_coin;
  logic [CW-1:0]      o_credit;
  logic [STOCK_W-1:0] o_stock;
  logic               o_sold_out;
  logic               o_busy;
  modport master (
    output i_coin_valid, i_coin, i_cancel, i_restock, i_change_ready,
    input  o_vend, o_reject, o_change_valid, o_change_coin, o_credit, o_stock, o_sold_out, o_busy
  );
  modport slave (
    input  i_coin_valid, i_coin, i_cancel, i_restock, i_change_ready,
    output o_vend, o_reject, o_change_valid, o_change_coin, o_credit, o_stock, o_sold_out, o_busy
  );
endinterface

// File: rtl/vending_machine_ctrl.sv
// vending_machine_ctrl: credit accumulation, single-item vend, Rs10/Rs5 change stream and stock tracking
module vending_machine_ctrl #(
  parameter int PRICE_UNITS = 3,
  parameter int CW          = 3,
  parameter int STOCK_INIT  = 8,
  parameter int STOCK_W     = 4
) (
  input logic                    i_clk,
  input logic                    i_rst_n,
  vending_machine_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, COLLECT, VEND, CHANGE} state_t;
  state_t             r_state;
  logic [CW-1:0]      r_credit;
  logic [STOCK_W-1:0] r_stock;
  logic               r_vend;
  logic               r_reject;
  logic               r_change_valid;
  logic [1:0]         r_change_coin;
  logic [1:0]         w_units;
  logic               w_legal;
  logic               w_open;
  logic               w_sold_out;
  logic               w_accept;
  logic               w_cancel_ok;
  logic [CW:0]        w_sum;
  logic [CW-1:0]      w_rem;
  logic [1:0]         w_credit_coin;
  logic [1:0]         w_rem_coin;
  always_comb begin
    w_units       = bus.i_coin == 2'b01 ? 2'd1 : bus.i_coin == 2'b10 ? 2'd2 : 2'd0;
    w_legal       = w_units != 2'd0;
    w_open        = r_state == IDLE || r_state == COLLECT;
    w_sold_out    = r_stock == '0;
    w_accept      = bus.i_coin_valid && w_open && w_legal && !w_sold_out && !bus.i_cancel;
    w_cancel_ok   = bus.i_cancel && r_state == COLLECT;
    w_sum         = {1'b0, r_credit} + (CW+1)'(w_units);
    w_rem         = r_credit - (r_credit >= CW'(2) ? CW'(2) : CW'(1));
    w_credit_coin = r_credit >= CW'(2) ? 2'b10 : 2'b01;
    w_rem_coin    = w_rem >= CW'(2) ? 2'b10 : 2'b01;
  end
  // Credit register doubles as the residual owed once the FSM leaves COLLECT
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= IDLE;
      r_credit       <= '0;
      r_stock        <= STOCK_W'(STOCK_INIT);
      r_vend         <= 1'b0;
      r_reject       <= 1'b0;
      r_change_valid <= 1'b0;
      r_change_coin  <= 2'b00;
    end else begin
      r_vend   <= 1'b0;
      r_reject <= bus.i_coin_valid && !w_accept;
      r_stock  <= bus.i_restock ? STOCK_W'(STOCK_INIT) :
                  (r_state == VEND && !w_sold_out) ? r_stock - STOCK_W'(1) : r_stock;
      case (r_state)
        IDLE, COLLECT: begin
          if (w_cancel_ok) begin
            r_state        <= CHANGE;
            r_change_valid <= 1'b1;
            r_change_coin  <= w_credit_coin;
          end else if (w_accept) begin
            if (w_sum >= (CW+1)'(PRICE_UNITS)) begin
              r_state  <= VEND;
              r_vend   <= 1'b1;
              r_credit <= CW'(w_sum - (CW+1)'(PRICE_UNITS));
            end else begin
              r_state  <= COLLECT;
              r_credit <= CW'(w_sum);
            end
          end
        end
        VEND: begin
          if (r_credit != '0) begin
            r_state        <= CHANGE;
            r_change_valid <= 1'b1;
            r_change_coin  <= w_credit_coin;
          end else begin
            r_state <= IDLE;
          end
        end
        CHANGE: begin
          if (bus.i_change_ready) begin
            r_credit <= w_rem;
            if (w_rem == '0) begin
              r_state        <= IDLE;
              r_change_valid <= 1'b0;
              r_change_coin  <= 2'b00;
            end else begin
              r_change_coin <= w_rem_coin;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.o_vend         = r_vend;
  assign bus.o_reject       = r_reject;
  assign bus.o_change_valid = r_change_valid;
  assign bus.o_change_coin  = r_change_coin;
  assign bus.o_credit       = r_credit;
  assign bus.o_stock        = r_stock;
  assign bus.o_sold_out     = w_sold_out;
  assign bus.o_busy         = r_state == VEND || r_state == CHANGE;
endmodule

// File: tb/tb_vending_machine_ctrl.sv
// tb_vending_machine_ctrl: directed vectors with a scoreboard of expected vend/reject/change events
module tb_vending_machine_ctrl;
  typedef enum int {EV_VEND, EV_REJ, EV_CHG} ev_e;
  typedef struct {ev_e kind; logic [1:0] coin;} ev_t;
  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;
  ev_t  sb[$];
  vending_machine_ctrl_if #(.CW(3), .STOCK_W(4)) v();
  vending_machine_ctrl_if #(.CW(3), .STOCK_W(4)) v1();
  vending_machine_ctrl #(.PRICE_UNITS(3), .CW(3), .STOCK_INIT(8), .STOCK_W(4)) dut  (.i_clk(clk), .i_rst_n(rst_n), .bus(v.slave));
  vending_machine_ctrl #(.PRICE_UNITS(3), .CW(3), .STOCK_INIT(1), .STOCK_W(4)) dut1 (.i_clk(clk), .i_rst_n(rst_n), .bus(v1.slave));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic push(input ev_e k, input logic [1:0] c);
    ev_t e;
    e.kind = k;
    e.coin = c;
    sb.push_back(e);
  endtask
  task automatic seen(input ev_e k, input logic [1:0] c, input string nm);
    ev_t e;
    n_vec++;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL %s: got unexpected event coin %b, expected no event", nm, c);
    end else begin
      e = sb.pop_front();
      if (e.kind != k || e.coin != c) begin
        n_err++;
        $display("FAIL %s: got kind %0d coin %b expected kind %0d coin %b", nm, k, c, e.kind, e.coin);
      end
    end
  endtask
  always @(negedge clk) begin
    if (rst_n) begin
      if (v.o_vend) seen(EV_VEND, 2'b00, "mon_vend");
      if (v.o_reject) seen(EV_REJ, 2'b00, "mon_reject");
      if (v.o_change_valid && v.i_change_ready) seen(EV_CHG, v.o_change_coin, "mon_change");
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic put(input logic [1:0] c);
    v.i_coin_valid = 1'b1;
    v.i_coin       = c;
  endtask
  task automatic idle_in();
    v.i_coin_valid = 1'b0;
    v.i_coin       = 2'b00;
    v.i_cancel     = 1'b0;
  endtask
  task automatic put1(input logic [1:0] c);
    v1.i_coin_valid = 1'b1;
    v1.i_coin       = c;
  endtask
  initial begin
    rst_n = 1'b0;
    idle_in();
    v.i_restock = 1'b0;
    v.i_change_ready = 1'b1;
    v1.i_coin_valid = 1'b0;
    v1.i_coin = 2'b00;
    v1.i_cancel = 1'b0;
    v1.i_restock = 1'b0;
    v1.i_change_ready = 1'b1;
    repeat (2) tick();
    chk("rst_vend", int'(v.o_vend), 0);
    chk("rst_cv", int'(v.o_change_valid), 0);
    chk("rst_coin", int'(v.o_change_coin), 0);
    chk("rst_credit", int'(v.o_credit), 0);
    chk("rst_stock", int'(v.o_stock), 8);
    chk("rst_sold_out", int'(v.o_sold_out), 0);
    chk("rst_busy", int'(v.o_busy), 0);
    rst_n = 1'b1;
    tick();
    put(2'b01); tick();
    put(2'b10); push(EV_VEND, 2'b00); tick();
    idle_in();
    chk("t1_busy", int'(v.o_busy), 1);
    chk("t1_vend", int'(v.o_vend), 1);
    tick();
    chk("t1_credit", int'(v.o_credit), 0);
    chk("t1_stock", int'(v.o_stock), 7);
    chk("t1_cv", int'(v.o_change_valid), 0);
    put(2'b10); tick();
    put(2'b10); push(EV_VEND, 2'b00); push(EV_CHG, 2'b01); tick();
    idle_in();
    chk("t2_residual", int'(v.o_credit), 1);
    tick();
    chk("t2_cv", int'(v.o_change_valid), 1);
    chk("t2_coin", int'(v.o_change_coin), 1);
    tick();
    chk("t2_busy", int'(v.o_busy), 0);
    chk("t2_stock", int'(v.o_stock), 6);
    chk("t2_cv_drop", int'(v.o_change_valid), 0);
    put(2'b01); tick();
    chk("t3_credit", int'(v.o_credit), 1);
    v.i_cancel = 1'b1;
    put(2'b10); push(EV_REJ, 2'b00); push(EV_CHG, 2'b01); tick();
    idle_in();
    chk("t3_busy", int'(v.o_busy), 1);
    chk("t3_novend", int'(v.o_vend), 0);
    tick();
    chk("t3_idle", int'(v.o_busy), 0);
    chk("t3_credit0", int'(v.o_credit), 0);
    chk("t3_stock", int'(v.o_stock), 6);
    put(2'b10); tick();
    chk("t4_credit", int'(v.o_credit), 2);
    idle_in();
    v.i_cancel = 1'b1;
    v.i_change_ready = 1'b0;
    tick();
    v.i_cancel = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_cv", int'(v.o_change_valid), 1);
      chk("t4_hold_coin", int'(v.o_change_coin), 2);
      chk("t4_hold_res", int'(v.o_credit), 2);
      tick();
    end
    v.i_change_ready = 1'b1;
    push(EV_CHG, 2'b10);
    tick();
    v.i_change_ready = 1'b0;
    chk("t4_res0", int'(v.o_credit), 0);
    chk("t4_cv_drop", int'(v.o_change_valid), 0);
    chk("t4_idle", int'(v.o_busy), 0);
    put(2'b00); push(EV_REJ, 2'b00); tick();
    put(2'b11); push(EV_REJ, 2'b00); tick();
    idle_in();
    chk("t6_inv_credit", int'(v.o_credit), 0);
    chk("t6_inv_busy", int'(v.o_busy), 0);
    tick();
    put1(2'b10); tick();
    put1(2'b01); tick();
    v1.i_coin_valid = 1'b0;
    chk("t5_vend", int'(v1.o_vend), 1);
    tick();
    chk("t5_stock0", int'(v1.o_stock), 0);
    chk("t5_sold_out", int'(v1.o_sold_out), 1);
    put1(2'b01); tick();
    v1.i_coin_valid = 1'b0;
    chk("t5_reject", int'(v1.o_reject), 1);
    chk("t5_credit", int'(v1.o_credit), 0);
    v1.i_restock = 1'b1; tick();
    v1.i_restock = 1'b0;
    chk("t5_restock", int'(v1.o_stock), 1);
    chk("t5_sold_clr", int'(v1.o_sold_out), 0);
    put1(2'b01); tick();
    v1.i_coin_valid = 1'b0;
    chk("t5_accept", int'(v1.o_credit), 1);
    chk("t5_noreject", int'(v1.o_reject), 0);
    put(2'b10); tick();
    put(2'b10); push(EV_VEND, 2'b00); tick();
    idle_in();
    tick();
    chk("t6_in_change", int'(v.o_change_valid), 1);
    chk("t6_stock_pre", int'(v.o_stock), 5);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_rst_cv", int'(v.o_change_valid), 0);
    chk("t6_rst_coin", int'(v.o_change_coin), 0);
    chk("t6_rst_credit", int'(v.o_credit), 0);
    chk("t6_rst_stock", int'(v.o_stock), 8);
    chk("t6_rst_busy", int'(v.o_busy), 0);
    chk("t6_rst_vend", int'(v.o_vend), 0);
    chk("t6_rst_reject", int'(v.o_reject), 0);
    chk("t6_rst_sold", int'(v.o_sold_out), 0);
    tick();
    rst_n = 1'b1;
    v.i_change_ready = 1'b1;
    repeat (2) tick();
    chk("sb_drain", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
